// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide, valid/ready handshake.
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle product for the four multiply ops.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_e;

    state_e      state_r, state_nxt_s;
    logic [4:0]  cnt_r;
    logic [2:0]  funct_r;
    logic        sign_q_r, sign_r_r;
    logic [63:0] acc_r, acc_step_s, prod_s;
    logic [31:0] opnd_r;
    logic        accept_s, is_div_s, sa_s, sb_s, special_s, fast_s;
    logic [31:0] mag_a_s, mag_b_s, quick_res_s, final_res_s;
    logic [32:0] shifted_s, diff_s, sum_s;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_a_s, ext_b_s, fprod_s;
`endif

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

    assign accept_s = valid_i && ready_o && !flush_i;
    assign ready_o  = (state_r == IDLE);
    assign is_div_s = funct3_i[2];
    // Signedness of A: MUL/MULH/MULHSU, DIV/REM; of B: MUL/MULH, DIV/REM.
    assign sa_s     = is_div_s ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign sb_s     = is_div_s ? !funct3_i[0] : !funct3_i[1];
    assign mag_a_s  = mag32(op_a_i, sa_s);
    assign mag_b_s  = mag32(op_b_i, sb_s);

`ifdef MULDIV_FAST_MUL_EN
    assign ext_a_s  = {{32{sa_s & op_a_i[31]}}, op_a_i};
    assign ext_b_s  = {{32{sb_s & op_b_i[31]}}, op_b_i};
    assign fprod_s  = ext_a_s * ext_b_s;
`endif

    // Results that need no iteration: divide special cases and the optional fast product.
    always_comb begin
        special_s   = 1'b0;
        fast_s      = 1'b0;
        quick_res_s = 32'd0;
        if (is_div_s && (op_b_i == 32'd0)) begin
            special_s   = 1'b1;
            quick_res_s = funct3_i[1] ? op_a_i : 32'hFFFF_FFFF;
        end else if (is_div_s && !funct3_i[0] && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF)) begin
            special_s   = 1'b1;
            quick_res_s = funct3_i[1] ? 32'd0 : 32'h8000_0000;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            fast_s      = !is_div_s;
            quick_res_s = (funct3_i[1:0] == 2'b00) ? fprod_s[31:0] : fprod_s[63:32];
`else
            fast_s      = 1'b0;
            quick_res_s = 32'd0;
`endif
        end
    end

    // One iteration step; acc holds {hi, lo} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        sum_s     = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        shifted_s = acc_r[63:31];
        diff_s    = shifted_s - {1'b0, opnd_r};
        if (funct_r[2]) begin
            acc_step_s = {(diff_s[32] ? shifted_s[31:0] : diff_s[31:0]), acc_r[30:0], !diff_s[32]};
        end else begin
            acc_step_s = {sum_s, acc_r[31:1]};
        end
        prod_s = sign_q_r ? (~acc_step_s + 64'd1) : acc_step_s;
        if (funct_r[2]) begin
            if (funct_r[1]) begin
                final_res_s = sign_r_r ? neg32(acc_step_s[63:32]) : acc_step_s[63:32];
            end else begin
                final_res_s = sign_q_r ? neg32(acc_step_s[31:0]) : acc_step_s[31:0];
            end
        end else begin
            final_res_s = (funct_r[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
        end
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (special_s || fast_s) ? DONE : ITER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ITER: begin
                if (cnt_r == 5'd31) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ITER;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
        if (flush_i) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State register and iteration counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cnt_r <= 5'd0;
            end else if (state_r == ITER) begin
                cnt_r <= cnt_r + 5'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Operand capture at accept, then one datapath step per ITER cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            funct_r  <= 3'd0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            acc_r    <= 64'd0;
            opnd_r   <= 32'd0;
        end else if (accept_s) begin
            funct_r  <= funct3_i;
            sign_q_r <= (sa_s & op_a_i[31]) ^ (sb_s & op_b_i[31]);
            sign_r_r <= sa_s & op_a_i[31];
            acc_r    <= {32'd0, (is_div_s ? mag_a_s : mag_b_s)};
            opnd_r   <= is_div_s ? mag_b_s : mag_a_s;
        end else if ((state_r == ITER) && !flush_i) begin
            acc_r <= acc_step_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Registered result and one-cycle valid pulse, both loaded on entry to DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= (state_nxt_s == DONE);
            if (state_nxt_s == DONE) begin
                result_o <= (state_r == IDLE) ? quick_res_s : final_res_s;
            end else begin
                result_o <= result_o;
            end
        end
    end

endmodule
